edge_frame_writer: RTL
======================

Name: edge_frame_writer

Overview:
- Sink end of the edge-detection pixel stream: accepts the valid-qualified 16-bit output of the canny top (`ready`/`out_data`).
- Restores byte order, counts column and row over the cropped output frame, and writes each pixel into a single-port frame-buffer RAM at a linear address.
- Signals frame completion, and flags stream overrun or underrun for software and the bench.
- Replaces the file-dump capture at the end of the simulation chain.

Parameters:
- OUT_W, 632, output frame width in pixels (input width 640 minus the 8-column border)
- OUT_H, 504, output frame height in lines
- DATA_W, 16, pixel width
- ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W >= OUT_W*OUT_H
- SWAP_BYTES, 1, 1 = swap byte lanes of in_data before writing; 0 = pass through

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse; arms capture of the next frame
- abort  in  1  single-cycle pulse; cancels capture and returns to IDLE
- in_valid  in  1  pixel strobe from canny top (`ready`)
- in_data  in  DATA_W  pixel from canny top (`out_data`)
- mem_we  out  1  frame-buffer write enable
- mem_addr  out  ADDR_W  frame-buffer write address
- mem_wdata  out  DATA_W  frame-buffer write data
- busy  out  1  high in ARMED or CAPTURE
- eol  out  1  one-cycle pulse coincident with the write of the last pixel of each line
- frame_done  out  1  one-cycle pulse coincident with the write of pixel OUT_W*OUT_H-1
- overrun  out  1  sticky; in_valid seen while in DONE; cleared by start or rst
- underrun  out  1  sticky; abort received in CAPTURE; cleared by start or rst

Behaviour:
- Reset (rst=1 at a clock edge, from any state, including mid-frame): state=IDLE; col, row and addr=0; all outputs 0. No partial-frame flush.
- States:
  - IDLE: in_valid ignored; start -> ARMED (clears overrun and underrun).
  - ARMED: first in_valid beat is pixel (0,0); it is accepted in that cycle -> CAPTURE.
  - CAPTURE: every in_valid beat is accepted. Gaps (in_valid=0) hold all counters; there is no timeout.
  - DONE: entered after the last pixel. in_valid sets overrun. start -> ARMED. abort -> IDLE.
- Latency: an accepted beat at edge N produces mem_we=1, mem_addr and mem_wdata valid for the cycle following edge N. The write is fully registered; mem_we is 0 in all other cycles.
- Data: mem_wdata = SWAP_BYTES ? {in_data[7:0], in_data[15:8]} : in_data.
- Addressing: mem_addr = row*OUT_W + col, kept as a running incrementer (no multiplier). col wraps at OUT_W-1 to 0, and row then increments. addr increments by 1 per accepted beat.
- eol: asserted with the write whose col = OUT_W-1.
- Last pixel (col=OUT_W-1, row=OUT_H-1):
  - eol and frame_done are asserted together with that write.
  - State -> DONE; counters reset to 0.
- Precedence, highest first: rst > abort > start > in_valid.
  - abort in ARMED or CAPTURE -> IDLE; counters cleared; any beat in that cycle is dropped; no frame_done. In CAPTURE it also sets underrun.
  - start in ARMED or CAPTURE is ignored.
  - start in DONE coincident with in_valid: -> ARMED, and that beat is accepted as pixel (0,0) of the new frame.
- busy is registered and follows state with no extra cycle.

Decomposition:
- Package canny_pkg holds:
  - frame constants IN_W=640, IN_H=512, OUT_W=632, OUT_H=504, PIX_W=16
  - the state enum (IDLE, ARMED, CAPTURE, DONE)
  - the function clog2-based ADDR_W default
- One sub-module: pix_addr_counter.
  - Holds col, row and addr with inc/clr inputs.
  - Outputs last_col and last_pix flags, so the FSM only sequences.

Test Plan:
- OUT_W=4, OUT_H=3, SWAP_BYTES=1: start, then 12 consecutive beats 16'h0100..16'h0B00 -> writes at addr 0..11 with data 16'h0001..16'h000B; eol with addr 3, 7 and 11; frame_done once with addr 11; busy low the cycle after.
- Same configuration, in_valid toggling 1/0 -> 12 writes, addresses contiguous, no skipped or duplicated address, frame_done only on the 12th write.
- Beats before start (IDLE) -> no mem_we. After a completed frame, 2 extra beats -> overrun=1, no writes; next start clears overrun.
- abort after 5 beats -> busy=0, underrun=1, no frame_done. A new start plus 12 beats restarts at addr 0.
- rst asserted mid-line (after 6 beats) -> all outputs 0 next cycle. start plus 12 beats yields a full frame from addr 0.
- Default parameters with 632*504 beats of a counter pattern -> final mem_addr=318527; frame_done once; 504 eol pulses.

Source files
------------

// File: rtl/edge_frame_writer_pkg.sv
// Shared frame constants, capture state encoding and address-width helper
// for the edge-detection output path.
package canny_pkg;
  localparam int IN_W  = 640;
  localparam int IN_H  = 512;
  localparam int OUT_W = 632;
  localparam int OUT_H = 504;
  localparam int PIX_W = 16;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_e;

  function automatic int addr_w_for(input int w, input int h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction

  localparam int ADDR_W_DEF = addr_w_for(OUT_W, OUT_H);
endpackage

// File: rtl/edge_frame_writer_if.sv
// Pixel stream in, frame-buffer write port out.
interface edge_frame_writer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 19
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport slave  (input  in_valid, in_data, output mem_we, mem_addr, mem_wdata);
  modport master (output in_valid, in_data, input  mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/edge_frame_writer_pix_addr_counter.sv
// Column/row/linear-address tracker for the cropped output frame.
// Wraps itself to (0,0) after the last pixel.
module pix_addr_counter #(
  parameter int OUT_W  = 632,
  parameter int OUT_H  = 504,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              clr,
  output logic [ADDR_W-1:0] addr,
  output logic              last_col,
  output logic              last_pix
);
  localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int RW = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign last_col = (col_q == CW'(OUT_W - 1));
  assign last_pix = last_col && (row_q == RW'(OUT_H - 1));
  assign addr     = addr_q;

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (clr || (inc && last_pix)) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (inc) begin
      addr_d = addr_q + 1'b1;
      if (last_col) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end
endmodule

// File: rtl/edge_frame_writer.sv
// Frame capture sequencer: accepts the canny output stream and issues one
// registered frame-buffer write per accepted beat.
module edge_frame_writer import canny_pkg::*; #(
  parameter int OUT_W      = canny_pkg::OUT_W,
  parameter int OUT_H      = canny_pkg::OUT_H,
  parameter int DATA_W     = canny_pkg::PIX_W,
  parameter int ADDR_W     = addr_w_for(OUT_W, OUT_H),
  parameter bit SWAP_BYTES = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  edge_frame_writer_if.slave  bus,
  output logic                busy,
  output logic                eol,
  output logic                frame_done,
  output logic                overrun,
  output logic                underrun
);
  state_e            state_q, state_d;
  logic              accept, cnt_clr, last_col, last_pix;
  logic [ADDR_W-1:0] cnt_addr;
  logic [DATA_W-1:0] pix;

  logic              we_q, we_d, eol_q, eol_d, fd_q, fd_d, busy_q, busy_d;
  logic              over_q, over_d, under_q, under_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  assign pix = SWAP_BYTES ? {bus.in_data[DATA_W/2-1:0], bus.in_data[DATA_W-1:DATA_W/2]}
                          : bus.in_data;

  pix_addr_counter #(.OUT_W(OUT_W), .OUT_H(OUT_H), .ADDR_W(ADDR_W)) u_cnt (
    .clk(clk), .rst(rst), .inc(accept), .clr(cnt_clr),
    .addr(cnt_addr), .last_col(last_col), .last_pix(last_pix)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    cnt_clr = 1'b0;
    over_d  = over_q;
    under_d = under_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = ARMED;
        over_d  = 1'b0;
        under_d = 1'b0;
      end
      ARMED, CAPTURE: begin
        if (abort) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
          if (state_q == CAPTURE) under_d = 1'b1;
        end else if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = last_pix ? DONE : CAPTURE;
        end
      end
      DONE: begin
        if (abort) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else if (start) begin
          over_d  = 1'b0;
          under_d = 1'b0;
          // a beat riding on the restart is pixel (0,0) of the new frame
          if (bus.in_valid) begin
            accept  = 1'b1;
            state_d = last_pix ? DONE : CAPTURE;
          end else begin
            state_d = ARMED;
          end
        end else if (bus.in_valid) begin
          over_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    we_d    = accept;
    addr_d  = accept ? cnt_addr : '0;
    wdata_d = accept ? pix : '0;
    eol_d   = accept && last_col;
    fd_d    = accept && last_pix;
    busy_d  = (state_d == ARMED) || (state_d == CAPTURE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      eol_q   <= 1'b0;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
      over_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      eol_q   <= eol_d;
      fd_q    <= fd_d;
      busy_q  <= busy_d;
      over_q  <= over_d;
      under_q <= under_d;
    end
  end

  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = busy_q;
  assign eol           = eol_q;
  assign frame_done    = fd_q;
  assign overrun       = over_q;
  assign underrun      = under_q;
endmodule
